mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised memory stage for the pipelined RV32I/RV64I core: performs sub-word loads and stores with byte enables, talks to data memory over a variable-latency request/acknowledge handshake, stalls the pipeline while an access is outstanding, and owns the Memory-to-Writeback pipeline register. Sits between the execute-stage register and the writeback mux. Forwarding outputs (`RegWriteM_o`, `RdM_o`, `ALUResultM_o`) feed the hazard unit.

## Interface
- `D_WIDTH`, 32: datapath width; legal values 32 or 64.
- `A_WIDTH`, 5: register index width.
- `MA_WIDTH`, 32: data-memory byte-address width.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `RegWriteM_i`, `MemReadM`, `MemWriteM` input 1 each: control from the EX/M register.
- `Funct3M` input 3: load/store size and sign.
- `ResultSrcM_i` input 2: writeback select, passed through.
- `PCPlus4M_i`, `ALUResultM_i`, `WriteDataM` input D_WIDTH: PC+4, effective address, store data.
- `RdM_i` input A_WIDTH: destination register.
- `FlushW` input 1: load a bubble into the M/W register.
- `mem_req` output 1, `mem_we` output 1, `mem_addr` output MA_WIDTH, `mem_be` output D_WIDTH/8, `mem_wdata` output D_WIDTH: memory request.
- `mem_ack` input 1, `mem_rdata` input D_WIDTH: completion; `mem_rdata` is valid only while `mem_ack` is high.
- `StallM` output 1: freezes the F/D/E/M registers.
- `MisalignM` output 1: misaligned access flag.
- `RegWriteM_o`, `RdM_o`, `ALUResultM_o`: combinational pass-throughs for forwarding.
- `RegWriteW`, `ResultSrcW`, `RdW`, `ALUResultW`, `ReadDataW`, `PCPlus4W`: M/W register outputs.

## Operation
- Lane = `ALUResultM_i[log2(D_WIDTH/8)-1:0]`.
- `mem_addr` = effective address aligned down to a D_WIDTH word.
- Funct3 encodings:
  - 000 LB/SB: 1 byte.
  - 001 LH/SH: 2 bytes.
  - 010 LW/SW: 4 bytes.
  - 011 LD/SD: 8 bytes; legal only when D_WIDTH=64, otherwise treated as misaligned.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended loads.
- Stores: replicate the low bytes of `WriteDataM` across all lanes. Set `mem_be` for the addressed bytes only.
- Loads: shift `mem_rdata` right by lane×8, then sign- or zero-extend to D_WIDTH.
- FSM has two states, IDLE and WAIT.
  - IDLE: if `MemReadM | MemWriteM` and the access is legal, drive `mem_req`=1 and `mem_we`=`MemWriteM`.
    - If `mem_ack` is high in the same cycle, the access completes with zero wait.
    - Otherwise go to WAIT with `StallM`=1.
  - WAIT: hold all `mem_*` outputs stable and keep `StallM`=1. When `mem_ack` is seen, return to IDLE and drop `StallM` combinationally in that cycle.
- `StallM` = (IDLE & access & !`mem_ack`) | (WAIT & !`mem_ack`).
- M/W register:
  - Captures on each edge where `StallM`=0.
  - `ReadDataW` captures the extracted load data.
  - While `StallM`=1, a bubble is loaded (`RegWriteW`=0) so writeback never repeats an instruction.
  - `FlushW` forces a bubble and has priority over capture.
- Non-memory instructions pass through without asserting `mem_req`.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - FSM goes to IDLE.
  - All W outputs clear to 0.
  - `mem_req`, `StallM`, `MisalignM` go to 0.
- Reset asserted in WAIT abandons the access. The memory must tolerate a dropped request.
- Latency with zero-wait memory: load data reaches `ReadDataW` at the edge after the M cycle.
- With an N-cycle ack, `StallM` is high for N cycles.
- `mem_ack` while `mem_req`=0 is ignored.
- A back-to-back memory instruction issues its request in the cycle immediately after the previous ack; there is no idle bubble.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword, word or doubleword access not naturally aligned raises `MisalignM`=1 for that M cycle.
  - `mem_req` is suppressed.
  - The W register receives a bubble.
- `MISALIGN_TRAP_EN` undefined:
  - `MisalignM` is tied 0.
  - The lane offset is truncated to size alignment, e.g. LW at 0x1006 behaves as LW at 0x1004.
  - The access proceeds normally.

## Test plan
- D_WIDTH=32, SB, addr 0x1003, data 0x000000A5, ack same cycle -> `mem_be`=4'b1000, `mem_wdata`=0xA5A5A5A5, `StallM` stays 0.
- LB, addr 0x2002, `mem_rdata`=0x12F03456 -> `ReadDataW`=0xFFFFFFF0. LBU at the same address -> 0x000000F0.
- LW with ack after 3 cycles -> `StallM` high for exactly 3 cycles, `mem_*` stable throughout, a single `RegWriteW` pulse.
- D_WIDTH=64, LWU, addr 0x4, `mem_rdata`=0x80000000_00000000 -> `ReadDataW`=0x0000000080000000.
- LH at 0x1001 with `MISALIGN_TRAP_EN` -> `MisalignM`=1, no `mem_req`, `RegWriteW`=0. Without the macro -> access at 0x1000 with `mem_be`=4'b0011.
- `rst_n` low during WAIT -> `StallM`, `mem_req` and `RegWriteW` drop to 0 immediately, without waiting for a clock edge. After release, a new load completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/acknowledge bus between the memory stage and data memory
interface mem_stage_lsu_if #(
  parameter int D_WIDTH  = 32,
  parameter int MA_WIDTH = 32
);
  logic                   mem_req;
  logic                   mem_we;
  logic [MA_WIDTH-1:0]    mem_addr;
  logic [D_WIDTH/8-1:0]   mem_be;
  logic [D_WIDTH-1:0]     mem_wdata;
  logic                   mem_ack;
  logic [D_WIDTH-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory stage: sub-word load/store, variable-latency handshake, M/W register
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating the lane offset.
module mem_stage_lsu #(
  parameter int D_WIDTH  = 32,
  parameter int A_WIDTH  = 5,
  parameter int MA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWriteM_i,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [2:0]          Funct3M,
  input  logic [1:0]          ResultSrcM_i,
  input  logic [D_WIDTH-1:0]  PCPlus4M_i,
  input  logic [D_WIDTH-1:0]  ALUResultM_i,
  input  logic [D_WIDTH-1:0]  WriteDataM,
  input  logic [A_WIDTH-1:0]  RdM_i,
  input  logic                FlushW,
  mem_stage_lsu_if.master     mem,
  output logic                StallM,
  output logic                MisalignM,
  output logic                RegWriteM_o,
  output logic [A_WIDTH-1:0]  RdM_o,
  output logic [D_WIDTH-1:0]  ALUResultM_o,
  output logic                RegWriteW,
  output logic [1:0]          ResultSrcW,
  output logic [A_WIDTH-1:0]  RdW,
  output logic [D_WIDTH-1:0]  ALUResultW,
  output logic [D_WIDTH-1:0]  ReadDataW,
  output logic [D_WIDTH-1:0]  PCPlus4W
);
  localparam int NB     = D_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic                 req_we_q, req_we_d;
  logic [MA_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [NB-1:0]        req_be_q, req_be_d;
  logic [D_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic                 reg_write_w_q, reg_write_w_d;
  logic [1:0]           result_src_w_q, result_src_w_d;
  logic [A_WIDTH-1:0]   rd_w_q, rd_w_d;
  logic [D_WIDTH-1:0]   alu_result_w_q, alu_result_w_d;
  logic [D_WIDTH-1:0]   read_data_w_q, read_data_w_d;
  logic [D_WIDTH-1:0]   pc_plus4_w_q, pc_plus4_w_d;

  logic [LANE_W-1:0]    lane, lane_al, size_mask;
  logic [3:0]           nbytes;
  logic                 access, size_ok, legal, issue, stall_c, capture, sign_bit;
  logic [MA_WIDTH-1:0]  addr_c;
  logic [NB-1:0]        be_c;
  logic [D_WIDTH-1:0]   wdata_c, shifted, load_data;

  always_comb begin
    access    = MemReadM | MemWriteM;
    lane      = ALUResultM_i[LANE_W-1:0];
    nbytes    = 4'd1 << Funct3M[1:0];
    size_mask = LANE_W'(nbytes - 4'd1);
    lane_al   = lane & ~size_mask;
    size_ok   = (Funct3M != 3'b111) && (int'(nbytes) <= NB);
`ifdef MISALIGN_TRAP_EN
    legal     = size_ok && ((lane & size_mask) == '0);
`else
    legal     = size_ok;
`endif
    issue     = access && legal;
    addr_c    = MA_WIDTH'(ALUResultM_i) & ~MA_WIDTH'(NB - 1);

    // Store data is replicated per access size so any enabled lane sees the right byte.
    be_c    = '0;
    wdata_c = '0;
    for (int i = 0; i < NB; i++) begin
      be_c[i] = (i >= int'(lane_al)) && (i < int'(lane_al) + int'(nbytes));
      case (Funct3M[1:0])
        2'd0:    wdata_c[8*i +: 8] = WriteDataM[7:0];
        2'd1:    wdata_c[8*i +: 8] = WriteDataM[8*(i%2) +: 8];
        2'd2:    wdata_c[8*i +: 8] = WriteDataM[8*(i%4) +: 8];
        default: wdata_c[8*i +: 8] = WriteDataM[8*i +: 8];
      endcase
    end

    shifted = mem.mem_rdata >> {lane_al, 3'b000};
    case (Funct3M[1:0])
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[D_WIDTH-1];
    endcase
    load_data = '0;
    for (int i = 0; i < D_WIDTH; i++) begin
      load_data[i] = (i < 8 * int'(nbytes)) ? shifted[i] : (sign_bit & ~Funct3M[2]);
    end
  end

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    stall_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_we_d    = MemWriteM;
        req_addr_d  = addr_c;
        req_be_d    = be_c;
        req_wdata_d = wdata_c;
        if (issue && !mem.mem_ack) begin
          state_d = S_WAIT;
          stall_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) state_d = S_IDLE;
        else             stall_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Stalled, flushed or illegal accesses load a bubble so writeback never repeats.
    capture        = !stall_c && !FlushW && !(access && !legal);
    reg_write_w_d  = capture ? RegWriteM_i  : 1'b0;
    result_src_w_d = capture ? ResultSrcM_i : 2'b00;
    rd_w_d         = capture ? RdM_i        : '0;
    alu_result_w_d = capture ? ALUResultM_i : '0;
    pc_plus4_w_d   = capture ? PCPlus4M_i   : '0;
    read_data_w_d  = (capture && MemReadM) ? load_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_be_q       <= '0;
      req_wdata_q    <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 2'b00;
      rd_w_q         <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus4_w_q   <= '0;
    end else begin
      state_q        <= state_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_be_q       <= req_be_d;
      req_wdata_q    <= req_wdata_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
    end
  end

  // Reset gates the combinational handshake outputs so they drop without a clock edge.
  assign mem.mem_req   = rst_n && ((state_q == S_WAIT) || issue);
  assign mem.mem_we    = (state_q == S_WAIT) ? req_we_q    : MemWriteM;
  assign mem.mem_addr  = (state_q == S_WAIT) ? req_addr_q  : addr_c;
  assign mem.mem_be    = (state_q == S_WAIT) ? req_be_q    : be_c;
  assign mem.mem_wdata = (state_q == S_WAIT) ? req_wdata_q : wdata_c;
  assign StallM        = rst_n && stall_c;
`ifdef MISALIGN_TRAP_EN
  assign MisalignM     = rst_n && access && !legal;
`else
  assign MisalignM     = 1'b0;
`endif

  assign RegWriteM_o   = RegWriteM_i;
  assign RdM_o         = RdM_i;
  assign ALUResultM_o  = ALUResultM_i;
  assign RegWriteW     = reg_write_w_q;
  assign ResultSrcW    = result_src_w_q;
  assign RdW           = rd_w_q;
  assign ALUResultW    = alu_result_w_q;
  assign ReadDataW     = read_data_w_q;
  assign PCPlus4W      = pc_plus4_w_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized bench for mem_stage_lsu, 32- and 64-bit instances against a byte-level model
module tb_mem_stage_lsu;
`ifdef MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, regw_i, mrd, mwr, flush;
  logic [2:0]  f3;
  logic [1:0]  rs_i;
  logic [4:0]  rd_i;
  logic [63:0] pc_i, alu_i, wd_i;

  logic        s32, m32, rwo32, rww32;
  logic [4:0]  rdo32, rdw32;
  logic [1:0]  rsw32;
  logic [31:0] aluo32, aluw32, rdat32, pcw32;
  logic        s64, m64, rwo64, rww64;
  logic [4:0]  rdo64, rdw64;
  logic [1:0]  rsw64;
  logic [63:0] aluo64, aluw64, rdat64, pcw64;

  mem_stage_lsu_if #(.D_WIDTH(32), .MA_WIDTH(32)) if32 ();
  mem_stage_lsu_if #(.D_WIDTH(64), .MA_WIDTH(32)) if64 ();

  mem_stage_lsu #(.D_WIDTH(32), .A_WIDTH(5), .MA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .RegWriteM_i(regw_i), .MemReadM(mrd), .MemWriteM(mwr),
    .Funct3M(f3), .ResultSrcM_i(rs_i), .PCPlus4M_i(pc_i[31:0]), .ALUResultM_i(alu_i[31:0]),
    .WriteDataM(wd_i[31:0]), .RdM_i(rd_i), .FlushW(flush), .mem(if32),
    .StallM(s32), .MisalignM(m32), .RegWriteM_o(rwo32), .RdM_o(rdo32), .ALUResultM_o(aluo32),
    .RegWriteW(rww32), .ResultSrcW(rsw32), .RdW(rdw32), .ALUResultW(aluw32),
    .ReadDataW(rdat32), .PCPlus4W(pcw32));

  mem_stage_lsu #(.D_WIDTH(64), .A_WIDTH(5), .MA_WIDTH(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .RegWriteM_i(regw_i), .MemReadM(mrd), .MemWriteM(mwr),
    .Funct3M(f3), .ResultSrcM_i(rs_i), .PCPlus4M_i(pc_i), .ALUResultM_i(alu_i),
    .WriteDataM(wd_i), .RdM_i(rd_i), .FlushW(flush), .mem(if64),
    .StallM(s64), .MisalignM(m64), .RegWriteM_o(rwo64), .RdM_o(rdo64), .ALUResultM_o(aluo64),
    .RegWriteW(rww64), .ResultSrcW(rsw64), .RdW(rdw64), .ALUResultW(aluw64),
    .ReadDataW(rdat64), .PCPlus4W(pcw64));

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ack(input bit a);
    if32.mem_ack = a;
    if64.mem_ack = a;
  endtask

  // Byte-level view of one access on a dw-bit bus.
  task automatic model(input int dw, input logic [2:0] fn, input logic [63:0] addr, wd, rdat,
                       output bit legal, output bit mis, output logic [31:0] ea,
                       output logic [7:0] be, output logic [63:0] wdat, output logic [63:0] ld);
    int nb, size, lane, lane_al;
    logic [63:0] sh, keep;
    nb      = dw / 8;
    size    = 1 << fn[1:0];
    lane    = int'(addr[2:0]) % nb;
    mis     = (size > nb) || ((lane % size) != 0);
    legal   = MIS_EN ? !mis : (size <= nb);
    lane_al = lane - (lane % size);
    ea      = addr[31:0] - 32'(lane);
    be      = 8'((1 << size) - 1) << lane_al;
    wdat    = '0;
    for (int i = 0; i < nb; i++) wdat[8*i +: 8] = wd[8*(i % size) +: 8];
    sh   = rdat >> (8 * lane_al);
    keep = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    sh   = sh & keep;
    if (!fn[2] && size < 8 && sh[8*size-1]) sh = sh | ~keep;
    ld = (dw == 32) ? (sh & 64'hFFFF_FFFF) : sh;
  endtask

  task automatic run_instr(input logic [2:0] fn, input bit ld_e, input bit st_e, input bit rw,
                           input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] r64,
                           input logic [31:0] r32, input int lat_req, input bit fl);
    bit l32, l64, mi32, mi64, mem, bub32, bub64;
    logic [31:0] ea32, ea64;
    logic [7:0]  be32, be64;
    logic [63:0] wdt32, wdt64, ld32, ld64;
    int lat;
    model(32, fn, addr, wd, {32'h0, r32}, l32, mi32, ea32, be32, wdt32, ld32);
    model(64, fn, addr, wd, r64, l64, mi64, ea64, be64, wdt64, ld64);
    mem = ld_e || st_e;
    lat = (mem && l32 && l64) ? lat_req : 0;
    f3 = fn; mrd = ld_e; mwr = st_e; regw_i = rw; alu_i = addr; wd_i = wd;
    pc_i = {$urandom, $urandom}; rd_i = 5'($urandom); rs_i = 2'($urandom);
    if32.mem_rdata = r32;
    if64.mem_rdata = r64;
    stall_cnt = 0;
    for (int c = 0; c <= lat; c++) begin
      set_ack(mem ? (c == lat) : 1'($urandom));
      flush = fl && (c == lat);
      @(negedge clk);
      if (s32) stall_cnt++;
      check_eq("stall32", s32, mem && l32 && (c < lat));
      check_eq("stall64", s64, mem && l64 && (c < lat));
      check_eq("req32", if32.mem_req, mem && l32);
      check_eq("req64", if64.mem_req, mem && l64);
      check_eq("mis32", m32, MIS_EN && mem && mi32);
      check_eq("mis64", m64, MIS_EN && mem && mi64);
      check_eq("fwd_alu64", aluo64, addr);
      check_eq("fwd_rw32", {rwo32, rdo32}, {rw, rd_i});
      if (mem && l32) begin
        check_eq("we32", if32.mem_we, st_e);
        check_eq("addr32", if32.mem_addr, ea32);
        check_eq("be32", if32.mem_be, be32[3:0]);
        if (st_e) check_eq("wdata32", if32.mem_wdata, wdt32[31:0]);
      end
      if (mem && l64) begin
        check_eq("we64", if64.mem_we, st_e);
        check_eq("addr64", if64.mem_addr, ea64);
        check_eq("be64", if64.mem_be, be64);
        if (st_e) check_eq("wdata64", if64.mem_wdata, wdt64);
      end
      @(posedge clk);
      #1;
      if (c < lat) begin
        check_eq("bubble32", rww32, 1'b0);
        check_eq("bubble64", rww64, 1'b0);
      end
    end
    bub32 = fl || (mem && !l32);
    bub64 = fl || (mem && !l64);
    check_eq("rww32", rww32, bub32 ? 1'b0 : rw);
    check_eq("rww64", rww64, bub64 ? 1'b0 : rw);
    check_eq("w_misc32", {rsw32, rdw32, aluw32, pcw32},
             bub32 ? 71'h0 : {rs_i, rd_i, addr[31:0], pc_i[31:0]});
    check_eq("alu_w64", aluw64, bub64 ? 64'h0 : addr);
    check_eq("pc_w64", pcw64, bub64 ? 64'h0 : pc_i);
    check_eq("rd_w64", {rsw64, rdw64}, bub64 ? 7'h0 : {rs_i, rd_i});
    check_eq("rdata_w32", rdat32, (!bub32 && ld_e) ? ld32 : 64'h0);
    check_eq("rdata_w64", rdat64, (!bub64 && ld_e) ? ld64 : 64'h0);
  endtask

  initial begin
    logic [2:0] fn;
    int k;
    rst_n = 1'b0; regw_i = 0; mrd = 0; mwr = 0; flush = 0; f3 = 0; rs_i = 0; rd_i = 0;
    pc_i = 0; alu_i = 0; wd_i = 0;
    set_ack(1'b0);
    if32.mem_rdata = '0;
    if64.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", {s32, s64, m32, m64}, 4'b0);
    check_eq("rst_req", {if32.mem_req, if64.mem_req}, 2'b0);
    check_eq("rst_w32", {rww32, rsw32, rdw32, aluw32, rdat32, pcw32}, 104'h0);
    check_eq("rst_w64", {rww64, aluw64 | rdat64 | pcw64}, 65'h0);
    rst_n = 1'b1;

    run_instr(3'b000, 0, 1, 0, 64'h1003, 64'hA5, 64'h0, 32'h0, 0, 0);
    check_eq("sb_be", if32.mem_be, 4'b1000);
    check_eq("sb_wdata", if32.mem_wdata, 32'hA5A5_A5A5);
    run_instr(3'b000, 1, 0, 1, 64'h2002, 64'h0, 64'h12F0_3456, 32'h12F0_3456, 0, 0);
    check_eq("lb_sext", rdat32, 32'hFFFF_FFF0);
    run_instr(3'b100, 1, 0, 1, 64'h2002, 64'h0, 64'h12F0_3456, 32'h12F0_3456, 0, 0);
    check_eq("lbu_zext", rdat32, 32'h0000_00F0);
    run_instr(3'b010, 1, 0, 1, 64'h3000, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 32'h8765_4321, 3, 0);
    check_eq("lw3_stall_cycles", stall_cnt, 3);
    check_eq("lw3_regwrite", rww32, 1'b1);
    run_instr(3'b110, 1, 0, 1, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 32'h0, 0, 0);
    check_eq("lwu64", rdat64, 64'h0000_0000_8000_0000);
    run_instr(3'b001, 1, 0, 1, 64'h1001, 64'h0, 64'h1122_3344_5566_7788, 32'h5566_7788, 1, 0);
    if (MIS_EN) begin
      check_eq("lh_mis_flag", m32, 1'b1);
      check_eq("lh_mis_noreq", if32.mem_req, 1'b0);
    end else begin
      check_eq("lh_trunc_be", if32.mem_be, 4'b0011);
      check_eq("lh_trunc_addr", if32.mem_addr, 32'h1000);
    end
    run_instr(3'b011, 1, 0, 1, 64'h18, 64'h0, 64'hF123_4567_89AB_CDEF, 32'h1, 2, 0);

    // Reset while a load is waiting for its acknowledge.
    f3 = 3'b010; mrd = 1; mwr = 0; regw_i = 1; alu_i = 64'h40; flush = 0;
    set_ack(1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("wait_stall", {s32, s64, if32.mem_req}, 3'b111);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_wait_stall", {s32, s64}, 2'b0);
    check_eq("rst_wait_req", {if32.mem_req, if64.mem_req}, 2'b0);
    check_eq("rst_wait_rw", {rww32, rww64}, 2'b0);
    @(posedge clk);
    #1;
    mrd = 0;
    rst_n = 1'b1;
    run_instr(3'b010, 1, 0, 1, 64'h80, 64'h0, 64'h0000_0000_CAFE_F00D, 32'hCAFE_F00D, 1, 0);
    check_eq("post_rst_lw", rdat32, 32'hCAFE_F00D);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 2);
      fn = (k == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      run_instr(fn, k == 1, k == 2, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
